rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- 8-requester arbiter that shares one resource between requesters.
- Uses an 8:3 priority-encode core on a rotated request vector.
- Supports fixed priority (highest index wins) and round-robin priority.
- Holds each grant until the owner drops its request or a hold timeout forces release.
- Sits between requester logic and any single-owner shared datapath.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant (legal range 2..255).
- CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req  input  8  request vector; bit i is requester i, level-sensitive.
- mode_rr  input  1  1 = round-robin, 0 = fixed priority (bit 7 highest); sampled only in IDLE.
- gnt  output  8  one-hot grant vector, registered.
- gnt_id  output  3  binary index of the current owner, registered; valid only when gnt_valid=1.
- gnt_valid  output  1  a grant is active, registered.
- timeout  output  1  one-cycle pulse, registered, on the cycle the grant is forcibly removed.

Behaviour:
- Reset (rst_n=0, asynchronous): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, state=IDLE, ptr=3'd7, hold_cnt=0.
- All outputs are registered; there are no combinational paths from req to the outputs.
- States:
  - IDLE: gnt_valid=0.
  - GRANT: gnt_valid=1 and gnt=1<<gnt_id.
- IDLE, when req!=0: compute the winner w and move to GRANT next cycle, with gnt_id=w, hold_cnt=0.
  - Grant latency is 1 cycle from req sampled to gnt asserted.
- IDLE, when req==0: remain in IDLE.
- Fixed mode winner: the highest set index of req, same as a plain 8:3 priority encoder.
- Round-robin mode winner: the first set bit scanning downward from ptr, wrapping 0 -> 7.
  - Implemented by rotating req so that ptr lands at bit 7, encoding, then un-rotating with modulo-8 addition.
- On every grant to w, in both modes: ptr <= (w-1) mod 8.
  - w=0 wraps ptr to 7.
  - The owner just served becomes lowest priority for the next round-robin arbitration.
- GRANT, owner releases (req[gnt_id]==0): go to IDLE next cycle.
  - gnt drops 1 cycle after req drops.
  - There is always exactly one idle cycle (gnt_valid=0) between consecutive grants.
- GRANT, hold expiry: when req[gnt_id]==1 and hold_cnt==MAX_HOLD-1, go to IDLE next cycle with timeout=1 for that one cycle.
  - The owner holds gnt for exactly MAX_HOLD cycles.
- GRANT otherwise: hold_cnt increments by 1 per cycle; saturation is never reached.
- Release and expiry on the same cycle: treat as a release; timeout stays 0.
- Changes to non-owner req bits during GRANT are ignored.
- Changes to mode_rr during GRANT are ignored.
- After a timeout, if the only requester is the same one, it is re-granted after the idle cycle.
- req bits with no owner present may toggle freely. Only the value present in the IDLE cycle decides the winner.
- rst_n asserted mid-grant: all outputs clear immediately. The first arbitration after release uses ptr=7.

Decomposition:
- Shared package: constants N_REQ=8, ID_W=3, PTR_RESET=3'd7, and the state encoding (IDLE=1'b0, GRANT=1'b1).
- One sub-module, prio_enc8: a purely combinational 8:3 highest-index encoder with an any_valid output. It is instantiated once on the rotated request vector.
- Rotation, the state machine, the hold counter and ptr all live in rr_arbiter_8.

Test Plan:
- Fixed priority: mode_rr=0, req=8'b0010_0110 → after 1 cycle gnt=8'b0010_0000, gnt_id=5. Drop req[5] → gnt=0 next cycle, then gnt_id=2 one cycle later.
- Round-robin rotation: mode_rr=1, req=8'hFF held, each owner drops its bit for 1 cycle after 3 cycles of grant. Required grant order is 7,6,5,4,3,2,1,0,7; ptr wraps from 0 to 7.
- Round-robin fairness: after a grant to 5 (ptr=4), req=8'b1010_0000 → gnt_id=7, because 5 is below ptr so the scan wraps to 7; the next grant is then 5.
- Timeout: MAX_HOLD=4, mode_rr=1, req=8'b0000_1000 held steady. Required per grant: gnt_valid high for exactly 4 cycles, timeout=1 on the following cycle, gnt_valid=0 for 1 cycle, then re-grant to 3. Repeat 3 times.
- Simultaneous release and expiry: drop req[owner] on the cycle hold_cnt==MAX_HOLD-1 → timeout stays 0 and the state goes to IDLE.
- Async reset mid-grant: pulse rst_n low between clock edges while gnt_id=4 → gnt, gnt_valid and timeout clear immediately without a clock edge. After release with req=8'b1001_0000 and mode_rr=1, the grant goes to 7 (ptr=7).

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and state encoding for the 8-requester round-robin arbiter.
package rr_arbiter_8_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   // Round-robin pointer value after reset: scanning starts at requester 7.
   localparam logic [ID_W-1:0] PTR_RESET = 3'd7;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter_8_prio_enc8.sv
// Purely combinational 8:3 priority encoder: the highest set index wins.
module prio_enc8
   import rr_arbiter_8_pkg::*;
(
   input  logic [N_REQ-1:0] req_in,
   output logic [ID_W-1:0]  id,
   output logic             any_valid
);

   // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
   always_comb begin
      id        = '0;
      any_valid = |req_in;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_in[i]) id = ID_W'(i);
      end
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester arbiter with fixed or round-robin priority and a hold timeout.
//
// Request/grant protocol: req[i] is a level request. A winner is chosen only
// in IDLE and is granted on the next clock edge (gnt one-hot, gnt_id, gnt_valid
// all registered). The owner keeps the grant while it holds req high, for at
// most MAX_HOLD cycles; dropping req releases the grant on the next edge.
// Every grant is followed by exactly one IDLE cycle before the next grant.
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       mode_rr,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   state_t            state, state_n;
   logic [ID_W-1:0]   ptr, ptr_n;
   logic [ID_W-1:0]   id_q, id_n;
   logic [CNT_W-1:0]  hold_cnt, cnt_n;
   logic [N_REQ-1:0]  gnt_q, gnt_n;
   logic              to_q, to_n;

   logic [ID_W-1:0]   eff_ptr;
   logic [3:0]        shamt;
   logic [N_REQ-1:0]  rot;
   logic [ID_W-1:0]   enc_id;
   logic              any_req;
   logic [ID_W-1:0]   win;

   // Rotate req so the scan start lands on bit 7; fixed mode uses start 7.
   always_comb begin
      eff_ptr = mode_rr ? ptr : PTR_RESET;
      shamt   = {1'b0, eff_ptr} + 4'd1;
      rot     = N_REQ'({req, req} >> shamt);
   end

   prio_enc8 u_enc (
      .req_in    (rot),
      .id        (enc_id),
      .any_valid (any_req)
   );

   // Undo the rotation: encoder index plus shift amount, modulo 8.
   assign win = enc_id + eff_ptr + 3'd1;

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= PTR_RESET;
         id_q     <= '0;
         hold_cnt <= '0;
         gnt_q    <= '0;
         to_q     <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         id_q     <= id_n;
         hold_cnt <= cnt_n;
         gnt_q    <= gnt_n;
         to_q     <= to_n;
      end
   end

   // Next-state logic: arbitrate in IDLE, release or expire in GRANT.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      id_n    = id_q;
      cnt_n   = hold_cnt;
      gnt_n   = gnt_q;
      to_n    = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_n = GRANT;
               id_n    = win;
               cnt_n   = '0;
               gnt_n   = N_REQ'(1) << win;
               // The owner just served becomes lowest priority next round.
               ptr_n   = win - 3'd1;
            end
         end
         GRANT: begin
            if (!req[id_q]) begin
               // Release wins over a coincident expiry: no timeout pulse.
               state_n = IDLE;
               gnt_n   = '0;
            end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
               state_n = IDLE;
               gnt_n   = '0;
               to_n    = 1'b1;
            end else begin
               cnt_n = hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   assign gnt       = gnt_q;
   assign gnt_id    = id_q;
   assign gnt_valid = (state == GRANT);
   assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 built with MAX_HOLD=4.
module tb_rr_arbiter_8;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       mode_rr;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   logic [2:0] exp_q[$];

   rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mode_rr   (mode_rr),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // owner = -1 when nobody holds the grant; held = cycles gnt shown so far.
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 7;
   bit m_to    = 1'b0;

   function automatic int pick_winner(input logic [7:0] r, input bit rr, input int p);
      int w;
      w = -1;
      if (rr) begin
         for (int k = 0; k < 8; k++) begin
            if (w < 0 && r[(p - k + 8) % 8]) w = (p - k + 8) % 8;
         end
      end else begin
         for (int k = 7; k >= 0; k--) begin
            if (w < 0 && r[k]) w = k;
         end
      end
      return w;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_held  = 0;
         m_ptr   = 7;
         m_to    = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         if (req != 8'h00) begin
            m_owner = pick_winner(req, mode_rr, m_ptr);
            m_held  = 1;
            m_ptr   = (m_owner + 7) % 8;
         end
      end else begin
         if (!req[m_owner]) begin
            m_owner = -1;
            m_to    = 1'b0;
         end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
         end else begin
            m_held = m_held + 1;
            m_to   = 1'b0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("cyc_valid", 32'(gnt_valid), 32'(m_owner >= 0));
         chk("cyc_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         chk("cyc_timeout", 32'(timeout), 32'(m_to));
         if (m_owner >= 0) chk("cyc_gnt_id", 32'(gnt_id), 32'(m_owner));
      end
   end

   // ---------------- driver tasks ----------------
   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0] e;
      rst_n   = 1'b0;
      req     = 8'h00;
      mode_rr = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_gnt_id", 32'(gnt_id), 32'd0);
      chk("rst_valid", 32'(gnt_valid), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      #11 rst_n = 1'b1;

      // Fixed priority: highest index wins, then the next one after an idle.
      step(1);
      req = 8'b0010_0110;
      step(1);
      chk("fix_gnt", 32'(gnt), 32'h20);
      chk("fix_id", 32'(gnt_id), 32'd5);
      req = 8'b0000_0110;
      step(1);
      chk("fix_rel_gnt", 32'(gnt), 32'd0);
      step(1);
      chk("fix_next_id", 32'(gnt_id), 32'd2);
      chk("fix_next_valid", 32'(gnt_valid), 32'd1);
      req = 8'h00;
      step(2);

      // Round-robin rotation from a fresh pointer.
      do_reset();
      mode_rr = 1'b1;
      req     = 8'hFF;
      exp_q   = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
      step(1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rr_order_id", 32'(gnt_id), 32'(e));
         chk("rr_order_valid", 32'(gnt_valid), 32'd1);
         step(2);
         req    = 8'hFF;
         req[e] = 1'b0;
         step(1);
         chk("rr_idle_gap", 32'(gnt_valid), 32'd0);
         req = 8'hFF;
         step(1);
      end
      req = 8'h00;
      step(2);

      // Fairness: after a grant to 5 the scan starts at 4 and wraps to 7.
      req = 8'b0010_0000;
      step(1);
      chk("fair_first", 32'(gnt_id), 32'd5);
      req = 8'h00;
      step(1);
      req = 8'b1010_0000;
      step(1);
      chk("fair_wrap", 32'(gnt_id), 32'd7);
      req = 8'b0010_0000;
      step(2);
      chk("fair_then5", 32'(gnt_id), 32'd5);
      req = 8'h00;
      step(2);

      // Hold timeout with a single steady requester, three rounds.
      req = 8'b0000_1000;
      step(1);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < MAX_HOLD; c++) begin
            chk("to_hold_valid", 32'(gnt_valid), 32'd1);
            chk("to_hold_id", 32'(gnt_id), 32'd3);
            chk("to_hold_pulse", 32'(timeout), 32'd0);
            step(1);
         end
         chk("to_pulse", 32'(timeout), 32'd1);
         chk("to_idle", 32'(gnt_valid), 32'd0);
         step(1);
      end
      chk("to_regrant", 32'(gnt_id), 32'd3);
      req = 8'h00;
      step(2);

      // Release on the same cycle the hold would expire: no timeout.
      req = 8'b0100_0000;
      step(1);
      chk("sim_id", 32'(gnt_id), 32'd6);
      step(MAX_HOLD - 1);
      req = 8'h00;
      step(1);
      chk("sim_valid", 32'(gnt_valid), 32'd0);
      chk("sim_timeout", 32'(timeout), 32'd0);
      step(1);

      // Asynchronous reset in the middle of a grant to 4.
      req = 8'b0001_0000;
      step(1);
      chk("ar_pre_id", 32'(gnt_id), 32'd4);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_gnt", 32'(gnt), 32'd0);
      chk("ar_valid", 32'(gnt_valid), 32'd0);
      chk("ar_timeout", 32'(timeout), 32'd0);
      rst_n   = 1'b1;
      req     = 8'b1001_0000;
      mode_rr = 1'b1;
      step(1);
      chk("ar_post_id", 32'(gnt_id), 32'd7);
      chk("ar_post_valid", 32'(gnt_valid), 32'd1);
      req = 8'h00;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
